uart_tx_fifo_core: RTL and testbench

Parametrised successor to the single-byte UART transmitter: an Avalon-MM slave with a transmit FIFO, a runtime baud divisor, and configurable frame format (5–8 data bits, parity, 1/2 stop bits, bit order). It sits on the system bus in the same position as the current UART core and drives one serial TXD line. Software can queue bursts instead of polling per byte. Status bit 0 keeps its meaning: "a TXDATA write will be accepted".

---
 rtl/uart_tx_fifo_core.sv | 200 ++++++++++++++++++++
 tb/tb_uart_tx_fifo_core.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_core.sv
// Avalon-MM UART transmitter with a TX FIFO, runtime baud divisor and
// configurable frame format (5-8 data bits, parity, 1/2 stop bits, bit order).
`timescale 1ns/1ps
module uart_tx_fifo_core #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic       clk_i,
  input  logic       arst_i,
  input  logic [3:0] avms_address_i,
  input  logic       avms_read_i,
  input  logic       avms_write_i,
  input  logic [7:0] avms_writedata_i,
  output logic [7:0] avms_readdata_o,
  output logic       uart_txd_o
);

  localparam int RESET_DIV = CLK_FREQ / BAUD_RATE;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  if ((RESET_DIV >> DIV_W) != 0) begin : g_bad_div
    $error("uart_tx_fifo_core: reset divisor does not fit in DIV_W bits");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo_core: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_e;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         idx_q, idx_d;
  logic [7:0]         frame_byte_q, frame_byte_d;
  logic [5:0]         frame_ctrl_q, frame_ctrl_d;
  logic [DIV_W-1:0]   frame_div_q, frame_div_d;
  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [5:0]         ctrl_q, ctrl_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               overflow_q, overflow_d;
  logic [7:0]         rdata_q, rdata_d;

  logic               push, push_ok, pop, fifo_empty, fifo_full, bit_end, txd;
  logic [DIV_W-1:0]   div_eff;
  logic [2:0]         n_last, data_pos;
  logic [7:0]         data_mask, status;

  assign push       = avms_write_i && (avms_address_i == 4'h0);
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign push_ok    = push && (!fifo_full || pop);
  assign div_eff    = (div_q < DIV_W'(2)) ? DIV_W'(2) : div_q;
  assign bit_end    = (cnt_q == frame_div_q - DIV_W'(1));
  assign n_last     = {1'b1, frame_ctrl_q[1:0]};
  assign status     = {3'b000, overflow_q, fifo_full, fifo_empty,
                       fifo_empty && (state_q == ST_IDLE), !fifo_full};

  // Frame sequencer; a pop always coincides with entering START and snapshots the frame config.
  always_comb begin
    state_d      = state_q;
    cnt_d        = bit_end ? '0 : cnt_q + DIV_W'(1);
    idx_d        = idx_q;
    frame_byte_d = frame_byte_q;
    frame_ctrl_d = frame_ctrl_q;
    frame_div_d  = frame_div_q;
    pop          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        pop   = !fifo_empty;
      end
      ST_START: if (bit_end) begin
        state_d = ST_DATA;
        idx_d   = 3'd0;
      end
      ST_DATA: if (bit_end) begin
        if (idx_q == n_last) begin
          idx_d   = 3'd0;
          state_d = frame_ctrl_q[2] ? ST_PARITY : ST_STOP;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      ST_PARITY: if (bit_end) begin
        state_d = ST_STOP;
        idx_d   = 3'd0;
      end
      ST_STOP: if (bit_end) begin
        if (frame_ctrl_q[4] && idx_q == 3'd0) idx_d = 3'd1;
        else if (!fifo_empty)                  pop = 1'b1;
        else                                   state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (pop) begin
      state_d      = ST_START;
      cnt_d        = '0;
      idx_d        = 3'd0;
      frame_byte_d = mem_q[rd_ptr_q];
      frame_ctrl_d = ctrl_q;
      frame_div_d  = div_eff;
    end
  end

  always_comb begin
    data_mask = 8'hFF;
    case (frame_ctrl_q[1:0])
      2'b00:   data_mask = 8'h1F;
      2'b01:   data_mask = 8'h3F;
      2'b10:   data_mask = 8'h7F;
      default: data_mask = 8'hFF;
    endcase
    data_pos = frame_ctrl_q[5] ? (n_last - idx_q) : idx_q;
    txd      = 1'b1;
    case (state_q)
      ST_START:  txd = 1'b0;
      ST_DATA:   txd = frame_byte_q[data_pos];
      ST_PARITY: txd = (^(frame_byte_q & data_mask)) ^ frame_ctrl_q[3];
      default:   txd = 1'b1;
    endcase
  end

  assign uart_txd_o = txd;

  always_comb begin
    wr_ptr_d   = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q;
    if (push_ok && !pop)      count_d = count_q + CW'(1);
    else if (!push_ok && pop) count_d = count_q - CW'(1);
    ctrl_d     = ctrl_q;
    div_d      = div_q;
    overflow_d = overflow_q;
    rdata_d    = rdata_q;
    if (avms_write_i) begin
      case (avms_address_i)
        4'h1: if (avms_writedata_i[4]) overflow_d = 1'b0;
        4'h2: ctrl_d = avms_writedata_i[5:0];
        4'h3: div_d = (div_q & ~DIV_W'(16'h00FF)) | DIV_W'({8'h00, avms_writedata_i});
        4'h4: div_d = (div_q & ~DIV_W'(16'hFF00)) | DIV_W'({avms_writedata_i, 8'h00});
        default: ;
      endcase
    end
    // A dropped push outranks a same-cycle clear so no overflow event is lost.
    if (push && !push_ok) overflow_d = 1'b1;
    if (avms_read_i) begin
      case (avms_address_i)
        4'h1:    rdata_d = status;
        4'h2:    rdata_d = {2'b00, ctrl_q};
        4'h3:    rdata_d = 8'(div_q);
        4'h4:    rdata_d = 8'(div_q >> 8);
        4'h5:    rdata_d = 8'(count_q);
        default: rdata_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      idx_q        <= 3'd0;
      frame_byte_q <= 8'h00;
      frame_ctrl_q <= 6'h03;
      frame_div_q  <= DIV_W'(2);
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ctrl_q       <= 6'h03;
      div_q        <= DIV_W'(RESET_DIV);
      overflow_q   <= 1'b0;
      rdata_q      <= 8'h00;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      frame_byte_q <= frame_byte_d;
      frame_ctrl_q <= frame_ctrl_d;
      frame_div_q  <= frame_div_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      ctrl_q       <= ctrl_d;
      div_q        <= div_d;
      overflow_q   <= overflow_d;
      rdata_q      <= rdata_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= avms_writedata_i;
  end

  assign avms_readdata_o = rdata_q;

endmodule

// File: tb/tb_uart_tx_fifo_core.sv
// Self-checking bench for uart_tx_fifo_core: bytes written to TXDATA are queued
// on a scoreboard and a serial monitor decodes and checks every frame on TXD.
`timescale 1ns/1ps
module tb_uart_tx_fifo_core;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] address = 4'h0;
   logic       read = 1'b0;
   logic       write = 1'b0;
   logic [7:0] writeData = 8'h00;
   logic [7:0] readData;
   logic       txd;

   int testsRun = 0;
   int testsFailed = 0;
   int cyc = 0;
   int frameCount = 0;
   bit monEnable = 1'b1;
   logic [7:0] sbQueue[$];
   int startLog[$];
   logic [5:0]  modelCtrl = 6'h03;
   logic [15:0] modelDiv = 16'd868;

   uart_tx_fifo_core dut (
      .clk_i(clock),
      .arst_i(reset),
      .avms_address_i(address),
      .avms_read_i(read),
      .avms_write_i(write),
      .avms_writedata_i(writeData),
      .avms_readdata_o(readData),
      .uart_txd_o(txd)
   );

   // 100 MHz clock plus a running edge counter used for exact timing checks
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // Every comparison in the bench goes through here
   task automatic checkOutput(input string tag, input int actual, input int expected);
      testsRun++;
      if (actual != expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Single-cycle bus write; also tracks the config the bench expects the DUT to hold
   task automatic busWrite(input logic [3:0] addr, input logic [7:0] data);
      address = addr; writeData = data; write = 1'b1;
      @(posedge clock); #1;
      write = 1'b0;
      if (addr == 4'h2) modelCtrl = data[5:0];
      if (addr == 4'h3) modelDiv[7:0] = data;
      if (addr == 4'h4) modelDiv[15:8] = data;
   endtask

   // Single-cycle bus read; readdata is registered so it is valid right after the edge
   task automatic busRead(input logic [3:0] addr, output logic [7:0] data);
      address = addr; read = 1'b1;
      @(posedge clock); #1;
      read = 1'b0;
      data = readData;
   endtask

   task automatic checkReg(input string tag, input logic [3:0] addr, input int expected);
      logic [7:0] value;
      busRead(addr, value);
      checkOutput(tag, value, expected);
   endtask

   // Push one byte into TXDATA and, if it should be transmitted, onto the scoreboard
   task automatic applyStimulus(input logic [7:0] value, input bit expectSent);
      busWrite(4'h0, value);
      if (expectSent) sbQueue.push_back(value);
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Return just after edge e-1 so the next bus operation lands on edge e
   task automatic waitToEdge(input int e);
      while (cyc < e - 1) begin
         @(posedge clock); #1;
      end
   endtask

   task automatic waitFrames(input int target, input int budget);
      int i = 0;
      while (frameCount < target && i < budget) begin
         @(posedge clock); #1;
         i++;
      end
      checkOutput("frame count reached", frameCount, target);
   endtask

   // A frame popped at edge s lasting len cycles leaves STOP at edge s+len
   task automatic checkIdleTiming(input string tag, input int s, input int len);
      logic [7:0] st;
      waitToEdge(s + len);
      busRead(4'h1, st);
      checkOutput({tag, " busy at last stop cycle"}, st[1], 0);
      busRead(4'h1, st);
      checkOutput({tag, " idle after frame"}, st[1], 1);
   endtask

   // Serial monitor: decodes each frame against the scoreboard head, sampling every cycle
   initial begin : monitor
      forever begin
         @(negedge clock);
         if (monEnable && !reset && txd === 1'b0) begin
            int expBits[12];
            int nb, n, d, errs, pos, waitCount;
            logic [7:0] b;
            logic par;
            startLog.push_back(cyc);
            if (sbQueue.size() == 0) begin
               checkOutput("unexpected frame", 1, 0);
               waitCount = 0;
               while (txd !== 1'b1 && waitCount < 20000) begin
                  @(negedge clock);
                  waitCount++;
               end
            end else begin
               b = sbQueue.pop_front();
               d = (modelDiv < 16'd2) ? 2 : int'(modelDiv);
               n = 5 + int'(modelCtrl[1:0]);
               expBits[0] = 0;
               nb = 1;
               par = 1'b0;
               for (int i = 0; i < n; i++) begin
                  pos = modelCtrl[5] ? (n - 1 - i) : i;
                  expBits[nb] = int'(b[pos]);
                  par = par ^ b[pos];
                  nb++;
               end
               if (modelCtrl[2]) begin
                  expBits[nb] = int'(par ^ modelCtrl[3]);
                  nb++;
               end
               expBits[nb] = 1;
               nb++;
               if (modelCtrl[4]) begin
                  expBits[nb] = 1;
                  nb++;
               end
               errs = 0;
               for (int i = 0; i < nb; i++) begin
                  for (int c = 0; c < d; c++) begin
                     if (i != 0 || c != 0) @(negedge clock);
                     if (txd !== expBits[i][0]) errs++;
                  end
               end
               checkOutput($sformatf("frame 0x%02h bad bit-cycles", b), errs, 0);
               frameCount++;
            end
         end
      end
   end

   // Hard stop in case the design never finishes a frame
   initial begin : watchdog
      #2ms;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main test sequence
   initial begin : stimulus
      int s, base, first, lows;

      // Reset state and register defaults
      repeat (3) @(posedge clock);
      #1;
      checkOutput("txd during reset", txd, 1);
      checkOutput("readdata during reset", readData, 0);
      reset = 1'b0;
      waitCycles(2);
      checkReg("reset STATUS", 4'h1, 8'h07);
      checkReg("reset CTRL", 4'h2, 8'h03);
      checkReg("reset DIVL", 4'h3, 8'h64);
      checkReg("reset DIVH", 4'h4, 8'h03);
      checkReg("reset LEVEL", 4'h5, 8'h00);
      checkReg("TXDATA reads zero", 4'h0, 8'h00);
      busWrite(4'h6, 8'hFF);
      checkReg("unmapped reads zero", 4'h6, 8'h00);
      checkReg("CTRL unchanged by unmapped write", 4'h2, 8'h03);

      // 8N1 frame at the reset divisor, with exact start latency and frame length
      $display("[TB] single byte 0x48 at 8N1, D=868");
      base = frameCount;
      applyStimulus(8'h48, 1'b1);
      s = cyc + 1;
      checkOutput("txd high after write edge", txd, 1);
      @(posedge clock); #1;
      checkOutput("start bit one cycle after write", txd, 0);
      checkIdleTiming("8N1", s, 8680);
      waitFrames(base + 1, 100);

      // Burst of 18 at D=16: 17 fit (one popped early), the last is dropped
      $display("[TB] burst of 18 bytes at D=16");
      busWrite(4'h3, 8'h10);
      busWrite(4'h4, 8'h00);
      base = frameCount;
      first = startLog.size();
      for (int i = 0; i < 18; i++) applyStimulus(8'hA0 + 8'(i), i < 17);
      checkReg("STATUS full with overflow", 4'h1, 8'h18);
      checkReg("LEVEL full", 4'h5, 16);
      busWrite(4'h1, 8'h10);
      checkReg("STATUS overflow cleared", 4'h1, 8'h08);
      waitFrames(base + 17, 17 * 160 + 200);
      if (startLog.size() >= first + 17)
         checkOutput("burst gap-free span", startLog[first + 16] - startLog[first], 16 * 160);
      waitCycles(5);
      checkReg("idle after burst", 4'h1, 8'h07);

      // 7 data bits, odd parity, two stop bits, MSB first
      $display("[TB] 0x55 with CTRL=0x3E");
      busWrite(4'h2, 8'h3E);
      base = frameCount;
      applyStimulus(8'h55, 1'b1);
      s = cyc + 1;
      checkIdleTiming("7O2 MSB-first", s, 176);
      waitFrames(base + 1, 50);

      // Divisor change mid-frame only affects the frames that follow
      $display("[TB] divisor change during a frame");
      busWrite(4'h2, 8'h03);
      base = frameCount;
      first = startLog.size();
      applyStimulus(8'h3C, 1'b1);
      applyStimulus(8'hC3, 1'b1);
      applyStimulus(8'h5A, 1'b1);
      waitCycles(40);
      busWrite(4'h3, 8'h20);
      busWrite(4'h4, 8'h00);
      waitFrames(base + 3, 160 + 640 + 200);
      if (startLog.size() >= first + 3) begin
         checkOutput("first frame kept D=16", startLog[first + 1] - startLog[first], 160);
         checkOutput("second frame used D=32", startLog[first + 2] - startLog[first + 1], 320);
      end

      // Reset in the middle of a frame with three bytes still queued
      $display("[TB] reset mid-frame");
      monEnable = 1'b0;
      for (int i = 0; i < 4; i++) applyStimulus(8'h00, 1'b0);
      waitCycles(50);
      checkOutput("txd low before reset", txd, 0);
      #2 reset = 1'b1;
      #1;
      checkOutput("txd high immediately on reset", txd, 1);
      checkOutput("readdata cleared by reset", readData, 0);
      modelCtrl = 6'h03;
      modelDiv = 16'd868;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      checkReg("STATUS after reset", 4'h1, 8'h07);
      checkReg("LEVEL after reset", 4'h5, 8'h00);
      checkReg("DIVL restored by reset", 4'h3, 8'h64);
      lows = 0;
      repeat (400) begin
         @(negedge clock);
         if (txd !== 1'b1) lows++;
      end
      checkOutput("no frames after reset", lows, 0);

      checkOutput("scoreboard drained", sbQueue.size(), 0);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
